// File: rtl/lenet_mem_pkg.sv
// ---------------------------------------------------------------------------
// lenet_mem_pkg
// Shared definitions for the LeNet feature-map memories:
//   - default geometry (channels per word, bits per channel, words per bank)
//   - bank_t : index of one of the two ping-pong banks
//   - lenet_addr_w() : address width needed to cover a given depth
// ---------------------------------------------------------------------------
package lenet_mem_pkg;

    localparam int LENET_FMAP_NCH   = 16;
    localparam int LENET_FMAP_DW    = 16;
    localparam int LENET_FMAP_DEPTH = 128;

    typedef logic [0:0] bank_t;

    // Never returns 0, so a depth-1 store still gets a usable address port.
    function automatic int lenet_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fmap_sdp_ram.sv
// ---------------------------------------------------------------------------
// fmap_sdp_ram
// Inferred simple-dual-port RAM: one write port, one registered read port,
// no reset (contents and read register power up undefined).
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable; the read register only updates when high
//   raddr_i  : read address
//   rdata_o  : registered read data, held while re_i is low
// ---------------------------------------------------------------------------
module fmap_sdp_ram #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    localparam int WORDS = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_pingpong_ram.sv
// ---------------------------------------------------------------------------
// fmap_pingpong_ram
// Double-buffered feature-map store. The producer fills the current write
// bank while the consumer reads the other; each bank carries a FULL flag and
// the two pointers toggle on wr_done / rd_done.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wr_en/addr/data     : write strobe, address within write bank, packed word
//   wr_done             : producer closes the current write bank
//   wr_ready            : current write bank is empty
//   rd_en/addr          : read strobe, address within read bank
//   rd_done             : consumer releases the current read bank
//   rd_ready            : current read bank is full
//   rd_data, rd_valid   : read result, one-cycle valid per accepted read
//   err                 : sticky protocol-violation flag
// Build option: define FMAP_RAM_OREG_EN to add an output register stage
// (read latency 2 instead of 1); handshake timing is unchanged.
// ---------------------------------------------------------------------------
module fmap_pingpong_ram
    import lenet_mem_pkg::*;
#(
    parameter  int N_CH   = LENET_FMAP_NCH,
    parameter  int DATA_W = LENET_FMAP_DW,
    parameter  int DEPTH  = LENET_FMAP_DEPTH,
    localparam int AW     = lenet_addr_w(DEPTH),
    localparam int WW     = N_CH * DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [WW-1:0] wr_data,
    input  logic          wr_done,
    output logic          wr_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_done,
    output logic          rd_ready,
    output logic [WW-1:0] rd_data,
    output logic          rd_valid,
    output logic          err
);

    logic [1:0] bank_full_q, bank_full_d;
    bank_t      wr_bank_q, wr_bank_d;
    bank_t      rd_bank_q, rd_bank_d;
    logic       err_q, err_d;
    logic       rd_pend_q, rd_pend_d;

    logic          wr_addr_ok, rd_addr_ok;
    logic          wr_acc, rd_acc;
    logic [WW-1:0] ram_rdata;

    assign wr_ready = ~bank_full_q[wr_bank_q];
    assign rd_ready =  bank_full_q[rd_bank_q];

    // Only meaningful for non-power-of-two depths; otherwise always true.
    assign wr_addr_ok = (32'(wr_addr) < DEPTH);
    assign rd_addr_ok = (32'(rd_addr) < DEPTH);

    assign wr_acc = wr_en & wr_ready & wr_addr_ok;
    assign rd_acc = rd_en & rd_ready & rd_addr_ok;

    always_comb begin
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        rd_pend_d   = rd_acc;
        err_d       = err_q
                    | (wr_en   & ~wr_acc)
                    | (rd_en   & ~rd_acc)
                    | (wr_done & ~wr_ready)
                    | (rd_done & ~rd_ready);
        // When both are legal the write bank is empty and the read bank is
        // full, so the two updates never touch the same flag.
        if (wr_done && wr_ready) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
        end
        if (rd_done && rd_ready) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full_q <= 2'b00;
            wr_bank_q   <= '0;
            rd_bank_q   <= '0;
            err_q       <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            err_q       <= err_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    assign err = err_q;

    // Physical address is {bank, addr}; a read issued with rd_done still
    // uses the bank being released because rd_bank_q updates after the edge.
    fmap_sdp_ram #(
        .WIDTH  (WW),
        .ADDR_W (AW + 1)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc & ~rst),
        .waddr_i ({wr_bank_q, wr_addr}),
        .wdata_i (wr_data),
        .re_i    (rd_acc & ~rst),
        .raddr_i ({rd_bank_q, rd_addr}),
        .rdata_o (ram_rdata)
    );

`ifdef FMAP_RAM_OREG_EN
    logic [WW-1:0] oreg_data_q;
    logic          oreg_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            oreg_data_q <= '0;
            oreg_vld_q  <= 1'b0;
        end else begin
            oreg_vld_q <= rd_pend_q;
            if (rd_pend_q) begin
                oreg_data_q <= ram_rdata;
            end
        end
    end

    assign rd_valid = oreg_vld_q;
    assign rd_data  = oreg_data_q;
`else
    // The RAM read register has no reset, so its output is masked to zero
    // until the first read accepted after reset has loaded it.
    logic seen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 1'b0;
        end else if (rd_acc) begin
            seen_q <= 1'b1;
        end
    end

    assign rd_valid = rd_pend_q;
    assign rd_data  = seen_q ? ram_rdata : '0;
`endif

endmodule

// File: tb/tb_fmap_pingpong_ram.sv
// ---------------------------------------------------------------------------
// tb_fmap_pingpong_ram
// Directed scenarios followed by biased random traffic. A reference model
// (two bank arrays, full flags, pointers) predicts each read; expected words
// go into a scoreboard queue that a negedge monitor drains when rd_valid is
// seen. Flags and the held rd_data value are compared every cycle.
// ---------------------------------------------------------------------------
module tb_fmap_pingpong_ram;

    localparam int N_CH   = 16;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 128;
    localparam int AW     = 7;
    localparam int WW     = N_CH * DATA_W;
`ifdef FMAP_RAM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, wr_done, rd_en, rd_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [WW-1:0] wr_data;
    logic          wr_ready, rd_ready, rd_valid, err;
    logic [WW-1:0] rd_data;

    always #5 clk = ~clk;

    fmap_pingpong_ram #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
    );

    // Reference model
    typedef struct {
        logic [WW-1:0] data;
        int            due;
    } exp_t;

    logic [WW-1:0] m_mem [2][DEPTH];
    bit            m_full [2];
    int            m_wb, m_rb;
    bit            m_err;
    exp_t          sb [$];
    logic [WW-1:0] m_last;

    int cycle     = 0;
    int rst_cycle = -1;
    bit started   = 1'b0;
    int checks    = 0;
    int failures  = 0;

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cycle, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] pat(input int addr);
        logic [WW-1:0] w;
        for (int k = 0; k < N_CH; k++) w[k*DATA_W +: DATA_W] = 16'(addr * 16 + k);
        return w;
    endfunction

    function automatic logic [WW-1:0] rnd_word();
        logic [WW-1:0] w;
        for (int k = 0; k < WW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock: model consumes the inputs at the edge, then inputs may change.
    task automatic tick();
        bit wrdy, rrdy;
        int wb0, rb0;
        @(posedge clk);
        cycle++;
        if (rst) begin
            m_full[0] = 0; m_full[1] = 0;
            m_wb = 0; m_rb = 0; m_err = 0;
            sb.delete();
            rst_cycle = cycle;
            started   = 1'b1;
        end else begin
            wrdy = !m_full[m_wb];
            rrdy =  m_full[m_rb];
            wb0  = m_wb;
            rb0  = m_rb;
            if (wr_en) begin
                if (wrdy && int'(wr_addr) < DEPTH) m_mem[wb0][wr_addr] = wr_data;
                else m_err = 1;
            end
            if (rd_en) begin
                if (rrdy && int'(rd_addr) < DEPTH) sb.push_back('{m_mem[rb0][rd_addr], cycle + LAT - 1});
                else m_err = 1;
            end
            if (wr_done) begin
                if (wrdy) begin m_full[wb0] = 1; m_wb = 1 - wb0; end
                else m_err = 1;
            end
            if (rd_done) begin
                if (rrdy) begin m_full[rb0] = 0; m_rb = 1 - rb0; end
                else m_err = 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; tick();
        rst = 0;
    endtask

    task automatic write(input int a, input logic [WW-1:0] d);
        idle(); wr_en = 1; wr_addr = AW'(a); wr_data = d; tick();
    endtask

    task automatic fill_bank();
        for (int a = 0; a < DEPTH; a++) write(a, pat(a));
        idle(); wr_done = 1; tick(); idle();
    endtask

    // Monitor
    initial begin
        bit exp_v;
        m_last = '0;
        forever begin
            @(negedge clk);
            if (started) begin
                if (cycle == rst_cycle) m_last = '0;
                chk("wr_ready", WW'(wr_ready), WW'(!m_full[m_wb]));
                chk("rd_ready", WW'(rd_ready), WW'(m_full[m_rb]));
                chk("err", WW'(err), WW'(m_err));
                exp_v = (sb.size() > 0) && (sb[0].due == cycle);
                chk("rd_valid", WW'(rd_valid), WW'(exp_v));
                if (exp_v) begin
                    exp_t e;
                    e = sb.pop_front();
                    m_last = e.data;
                    $display("RD cycle=%0d want_lo=%h got_lo=%h", cycle, e.data[31:0], rd_data[31:0]);
                end else if (sb.size() > 0 && sb[0].due < cycle) begin
                    void'(sb.pop_front());
                end
                chk("rd_data", rd_data, m_last);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cycle);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;

        // Fill bank 0, close it, read addr 5 channel 3.
        fill_bank();
        tick();
        rd_en = 1; rd_addr = 7'd5; tick(); idle();
        if (LAT == 2) tick();
        chk("addr5_valid", WW'(rd_valid), WW'(1));
        chk("addr5_ch3", WW'(rd_data[3*DATA_W +: DATA_W]), WW'(16'h0053));

        // Fill bank 1, both full; extra write dropped, bank 0 unchanged.
        fill_bank();
        write(7, rnd_word()); idle();
        tick();
        rd_en = 1; rd_addr = 7'd7; tick(); idle();

        // Read together with rd_done: data from bank 0, then bank 1 current.
        rd_en = 1; rd_addr = 7'd10; rd_done = 1; tick(); idle();
        rd_en = 1; rd_addr = 7'd10; tick(); idle();
        tick(); tick();

        // One bank full, wr_done and rd_done together.
        do_reset();
        for (int a = 0; a < 4; a++) write(a, pat(a));
        idle(); wr_done = 1; tick(); idle();
        wr_done = 1; rd_done = 1; tick(); idle();
        tick();

        // Illegal read sets sticky err; reset clears it.
        do_reset();
        rd_en = 1; rd_addr = 7'd0; tick(); idle();
        tick(); tick(); tick();
        do_reset();
        tick();

        // Reset right after an accepted read discards it.
        write(3, pat(3));
        idle(); wr_done = 1; tick(); idle();
        rd_en = 1; rd_addr = 7'd3; tick(); idle();
        rst = 1; tick(); rst = 0;
        tick(); tick();

        // Biased random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit wrdy, rrdy;
            wrdy = !m_full[m_wb];
            rrdy =  m_full[m_rb];
            rst     = ($urandom_range(0, 399) == 0);
            wr_en   = wrdy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            wr_addr = AW'($urandom);
            wr_data = rnd_word();
            rd_en   = rrdy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            rd_addr = AW'($urandom);
            wr_done = wrdy ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 99) == 0);
            rd_done = rrdy ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0;
        idle();
        for (int i = 0; i < 5; i++) tick();
        chk("sb_empty", WW'(sb.size()), WW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmap_pingpong_ram.md
Name: fmap_pingpong_ram

Overview:
- Parametrised, double-buffered feature-map store between a layer's producer (conv/pool output) and its consumer (next layer's input fetch).
- Packs N_CH channels of DATA_W into one wide word per address.
- Two banks with full/empty handshake: the producer fills one bank while the consumer reads the other.
- Replaces the fixed 16-channel, 128-deep, vendor-IP single-bank feature-map RAMs with inferred memory.

Parameters:
- N_CH, 16, channels packed per word; channel k occupies bits [k*DATA_W +: DATA_W], channel 0 in the LSBs.
- DATA_W, 16, bits per channel sample.
- DEPTH, 128, words per bank; AW = clog2(DEPTH) is a derived localparam.

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address within the current write bank
- wr_data  in  N_CH*DATA_W  packed write word
- wr_done  in  1  pulse: producer finished the current write bank
- wr_ready  out  1  current write bank is EMPTY; writes accepted
- rd_en  in  1  read strobe
- rd_addr  in  AW  read address within the current read bank
- rd_done  in  1  pulse: consumer finished the current read bank
- rd_ready  out  1  current read bank is FULL; reads accepted
- rd_data  out  N_CH*DATA_W  packed read word
- rd_valid  out  1  rd_data holds the result of an accepted read
- err  out  1  sticky protocol-violation flag

Behaviour:
- State:
  - bank_full[1:0], one bit per bank.
  - wr_bank and rd_bank pointer bits.
  - Physical address is {bank, addr}.
- Reset (rst=1 at a clock edge):
  - bank_full=0, wr_bank=0, rd_bank=0.
  - Outputs: rd_valid=0, rd_data=0, err=0, wr_ready=1, rd_ready=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards in-flight reads: rd_valid is 0 on the cycle after reset.
- Combinational flags: wr_ready = !bank_full[wr_bank]; rd_ready = bank_full[rd_bank].
- Write acceptance:
  - A write is accepted when wr_en & wr_ready & (wr_addr < DEPTH).
  - Otherwise it is dropped and err is set (wr_en=0 is never an error).
- wr_done:
  - With wr_ready=1: set bank_full[wr_bank] and toggle wr_bank.
  - With wr_ready=0: ignored; err is set.
  - A write in the same cycle as wr_done lands in the bank being closed.
- Read acceptance and latency:
  - A read is accepted when rd_en & rd_ready & (rd_addr < DEPTH).
  - Result appears next cycle: rd_valid=1 and rd_data = mem[{rd_bank_at_issue, rd_addr}].
  - Rejected reads set err and produce no rd_valid.
  - rd_data holds its last value when no read completes; rd_valid is high for exactly one cycle per accepted read.
- rd_done:
  - With rd_ready=1: clear bank_full[rd_bank] and toggle rd_bank.
  - With rd_ready=0: ignored; err is set.
  - A read in the same cycle as rd_done uses the bank being released and still returns valid data.
- Simultaneous wr_done and rd_done:
  - Both apply; they always target different banks when both are legal.
  - Flags update on the next cycle. Example: both banks FULL plus rd_done gives wr_ready=1 next cycle.
- Read-during-write on the same physical address cannot occur, because the write bank is EMPTY and the read bank is FULL.
- err clears only on rst.

Optional Feature:
- Macro: FMAP_RAM_OREG_EN.
- Defined:
  - Adds an output register stage; read latency is 2 cycles.
  - rd_valid is delayed in lockstep with the data.
  - The register resets to 0.
- Undefined: read latency is 1 cycle.
- All handshake and flag timing is identical in both cases.

Decomposition:
- Shared package lenet_mem_pkg:
  - Defaults LENET_FMAP_NCH=16, LENET_FMAP_DW=16, LENET_FMAP_DEPTH=128.
  - clog2-based address-width helper.
  - Bank-index typedef.
- Sub-module fmap_sdp_ram: inferred simple-dual-port RAM, depth 2*DEPTH, width N_CH*DATA_W, one write port, one registered read port, no reset.
- The top level holds the handshake, pointer and error logic, and the optional output register.

Test Plan:
- Reset, write addr 0..127 with channel k = addr*16+k into bank 0, then wr_done -> wr_ready stays 1 (bank 1 empty) and rd_ready=1 next cycle; reading addr 5 gives channel 3 = 0x0053 one cycle later (two with FMAP_RAM_OREG_EN).
- Fill bank 0, wr_done, fill bank 1, wr_done -> wr_ready=0; an extra wr_en is dropped and err=1; memory is unchanged on readback.
- Both banks full, rd_done asserted in the same cycle as rd_en addr 10 -> rd_valid=1 with bank-0 data; next cycle rd_bank=1 and wr_ready=1.
- With one bank full, wr_done and rd_done in the same cycle -> next cycle bank_full has bank 1 set and bank 0 cleared, rd_ready=1, wr_ready=1, err=0.
- rd_en while rd_ready=0, and wr_en with wr_addr=DEPTH -> no rd_valid, err=1 and sticky until rst.
- Assert rst one cycle after an accepted read -> rd_valid=0, rd_data=0, wr_ready=1, rd_ready=0 on the following cycle.
